// File: rtl/operand_sequencer_pkg.sv
// Shared constants for the operand sequencer: LED state encodings and the
// default debounce settings (10 ms at 50 MHz).
package operand_sequencer_pkg;

  localparam logic [1:0] ST_WAIT_A = 2'd0;
  localparam logic [1:0] ST_WAIT_B = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int CNT_W_DEFAULT           = 19;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
  } operands_t;

endpackage

// File: rtl/operand_sequencer_key_conditioner.sv
// Pushbutton conditioning: 2-flop synchroniser, optional debounce (DEBOUNCE_EN)
// and a registered one-cycle pulse on each released->pressed transition.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_press
);

  logic r_sync1;
  logic r_sync2;
  logic r_filt_d;
  logic r_press;
  logic w_filt;

  // Synchroniser idles at 1 so a key held through reset is first seen released.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

`ifdef DEBOUNCE_EN
  logic             r_filt;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_filt <= 1'b1;
      r_cnt  <= '0;
    end else if (r_sync2 == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      r_filt <= r_sync2;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_filt = r_filt;
`else
  logic w_unused_params;
  assign w_unused_params = (DEBOUNCE_CYCLES > CNT_W);
  assign w_filt          = r_sync2;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_filt_d <= 1'b1;
      r_press  <= 1'b0;
    end else begin
      r_filt_d <= w_filt;
      r_press  <= r_filt_d & ~w_filt;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/operand_sequencer.sv
// Captures operand A, then operand B and carry-in, from one switch bank on
// successive key presses. Optional key debounce via macro DEBOUNCE_EN.
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [4:0] SW,
  input  logic       KEY_N,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic       op_cin,
  output logic       op_valid,
  output logic [1:0] state
);

  logic      w_press;
  logic [1:0] r_state;
  operands_t r_ops;
  logic      r_valid;

  key_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_key (
    .i_clk   (CLOCK_50),
    .i_rst   (RESET),
    .i_key_n (KEY_N),
    .o_press (w_press)
  );

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_WAIT_A;
      r_ops   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_WAIT_A: if (w_press) begin
          r_ops.a <= SW[3:0];
          r_state <= ST_WAIT_B;
        end
        ST_WAIT_B: if (w_press) begin
          r_ops.b   <= SW[3:0];
          r_ops.cin <= SW[4];
          r_valid   <= 1'b1;
          r_state   <= ST_READY;
        end
        // Operands are kept so the adder display stays meaningful until overwritten.
        ST_READY: if (w_press) begin
          r_valid <= 1'b0;
          r_state <= ST_WAIT_A;
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ST_WAIT_A;
        end
      endcase
    end
  end

  assign op_a     = r_ops.a;
  assign op_b     = r_ops.b;
  assign op_cin   = r_ops.cin;
  assign op_valid = r_valid;
  assign state    = r_state;

endmodule
